rs422_rx_channel: RTL and testbench

Per-port RS-422 asynchronous receiver. Deserialises 8N1 frames from one rx line and buffers bytes in a small FIFO. The collector drains the FIFO through a ready/read/used handshake and writes each byte into that port's RAM region. One instance per input port (10 total), each with a runtime baud divisor from the control register file.

---
 rtl/rs422_rx_channel.sv | 225 ++++++++++++++++++++++
 tb/tb_rs422_rx_channel.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs422_rx_channel.sv
`default_nettype none
// ============================================================================
// Module   : rs422_rx_channel
// Purpose  : Per-port RS-422 8N1 asynchronous receiver with a byte FIFO that
//            a collector drains through a ready/read/used handshake.
// Ports    : i_clk   - sampling clock
//            i_rst   - asynchronous active-low reset
//            i_rx    - serial line, idle high, asynchronous to i_clk
//            i_baud  - clocks per oversample tick (0 behaves as 1)
//            i_read  - pop request from the collector
//            o_ready - FIFO holds at least one byte
//            o_used  - one-cycle pulse, o_D carries the byte just popped
//            o_D     - popped byte while o_used, else 8'h00 (bus-OR safe)
//            o_ferr  - one-cycle pulse, framing error, byte discarded
//            o_ovf   - one-cycle pulse, byte completed while FIFO full
// Revision : 1.0 - initial release
// ============================================================================
module rs422_rx_channel #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int OVS   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    input  logic [15:0] i_baud,
    input  logic        i_read,
    output logic        o_ready,
    output logic        o_used,
    output logic [7:0]  o_D,
    output logic        o_ferr,
    output logic        o_ovf
);

    localparam logic [3:0]  c_half  = 4'(OVS / 2 - 1);
    localparam logic [3:0]  c_last  = 4'(OVS - 1);
    localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_rx_meta, r_rxs;
    logic          r_armed;
    logic [15:0]   r_cnt, r_div;
    logic [15:0]   w_baud_eff;
    logic          w_tick;
    logic [3:0]    r_st, w_st_nxt;
    logic [2:0]    r_bc, w_bc_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          w_push_req, w_ferr_req;

    logic [7:0]    r_mem [DEPTH];
    logic [AW:0]   r_wr, r_rd;
    logic [AW:0]   w_count;
    logic          w_full, w_pop, w_push, w_ovf_req;
    logic [7:0]    r_data;
    logic          r_used, r_ferr, r_ovf;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; reset to the idle (high) line level
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick generator. The divisor is captured while idle and at
    // every wrap, so a new i_baud only takes effect on a counter wrap.
    // ------------------------------------------------------------------
    assign w_baud_eff = (i_baud == 16'd0) ? 16'd1 : i_baud;
    assign w_tick     = (r_state != S_IDLE) && (r_cnt == r_div - 16'd1);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= 16'd0;
            r_div <= 16'd1;
        end else if (r_state == S_IDLE || w_tick) begin
            r_cnt <= 16'd0;
            r_div <= w_baud_eff;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_st    <= 4'd0;
            r_bc    <= 3'd0;
            r_shift <= 8'h00;
            r_armed <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_st    <= w_st_nxt;
            r_bc    <= w_bc_nxt;
            r_shift <= w_shift_nxt;
            // A framing error disarms the receiver until the line is seen
            // high again, so a line stuck low reports only one error.
            if (w_ferr_req)
                r_armed <= 1'b0;
            else if (r_rxs)
                r_armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_st_nxt    = r_st;
        w_bc_nxt    = r_bc;
        w_shift_nxt = r_shift;
        w_push_req  = 1'b0;
        w_ferr_req  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_st_nxt = 4'd0;
                if (!r_rxs && r_armed)
                    w_state_nxt = S_START;
            end
            S_START: begin
                if (w_tick) begin
                    if (r_st == c_half) begin
                        w_st_nxt = 4'd0;
                        if (r_rxs) begin
                            w_state_nxt = S_IDLE;   // glitch, not a start bit
                        end else begin
                            w_state_nxt = S_DATA;
                            w_bc_nxt    = 3'd0;
                        end
                    end else begin
                        w_st_nxt = r_st + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_st == c_last) begin
                        w_st_nxt    = 4'd0;
                        w_shift_nxt = {r_rxs, r_shift[7:1]};   // LSB first
                        if (r_bc == 3'd7)
                            w_state_nxt = S_STOP;
                        else
                            w_bc_nxt = r_bc + 3'd1;
                    end else begin
                        w_st_nxt = r_st + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_st == c_last) begin
                        w_st_nxt    = 4'd0;
                        w_state_nxt = S_IDLE;
                        if (r_rxs)
                            w_push_req = 1'b1;
                        else
                            w_ferr_req = 1'b1;
                    end else begin
                        w_st_nxt = r_st + 4'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Byte FIFO. A pop in the same cycle frees the slot a full FIFO needs,
    // so push is still accepted then.
    // ------------------------------------------------------------------
    assign w_count   = r_wr - r_rd;
    assign w_full    = (w_count == c_depth);
    assign w_pop     = i_read && (w_count != '0);
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovf_req = w_push_req && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr[AW-1:0]] <= r_shift;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_data <= 8'h00;
            r_used <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_data <= w_pop ? r_mem[r_rd[AW-1:0]] : 8'h00;
            r_used <= w_pop;
            r_ferr <= w_ferr_req;
            r_ovf  <= w_ovf_req;
        end
    end

    assign o_ready = (w_count != '0);
    assign o_used  = r_used;
    assign o_D     = r_data;
    assign o_ferr  = r_ferr;
    assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rs422_rx_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs422_rx_channel
// Purpose  : Self-checking bench for rs422_rx_channel. Frames are driven
//            bit by bit; a queue model of the FIFO follows the frames sent
//            and the reads issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs422_rx_channel;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [15:0] baud;
    logic        rd;
    logic        ready, used, ferr, ovf;
    logic [7:0]  dout;

    int          n_checks;
    int          n_errors;

    // model state
    logic [7:0]  q [$];
    logic        exp_used;
    logic [7:0]  exp_d;
    int          exp_ferr, exp_ovf;
    int          n_ferr_seen, n_ovf_seen;
    logic        chk_ready;

    rs422_rx_channel #(.DEPTH(16), .AW(4), .OVS(16)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_rx    (rx),
        .i_baud  (baud),
        .i_read  (rd),
        .o_ready (ready),
        .o_used  (used),
        .o_D     (dout),
        .o_ferr  (ferr),
        .o_ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_ready", {31'd0, ready}, 0);
            check("rst_used",  {31'd0, used},  0);
            check("rst_D",     {24'd0, dout},  0);
            check("rst_ferr",  {31'd0, ferr},  0);
            check("rst_ovf",   {31'd0, ovf},   0);
        end else begin
            check("used", {31'd0, used}, {31'd0, exp_used});
            check("D",    {24'd0, dout}, {24'd0, exp_d});
            if (chk_ready)
                check("ready", {31'd0, ready}, (q.size() != 0) ? 1 : 0);
            if (ferr) n_ferr_seen++;
            if (ovf)  n_ovf_seen++;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int bd, input int extra_low);
        int p;
        p = 16 * ((bd == 0) ? 1 : bd);
        chk_ready = 1'b0;
        baud = 16'(bd);
        @(posedge clk); #1 rx = 1'b0;
        repeat (p) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (p) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (p + extra_low) @(posedge clk);
        #1 rx = 1'b1;
        if (stop_bit) begin
            if (q.size() < 16) q.push_back(b);
            else               exp_ovf++;
        end else begin
            exp_ferr++;
        end
        chk_ready = 1'b1;
    endtask

    task automatic read_byte(output logic [7:0] d, output logic u);
        @(posedge clk); #1 rd = 1'b1;
        @(posedge clk); #1 rd = 1'b0;
        if (q.size() > 0) begin
            exp_used = 1'b1;
            exp_d    = q.pop_front();
        end
        @(negedge clk);
        d = dout;
        u = used;
        @(posedge clk); #1;
        exp_used = 1'b0;
        exp_d    = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] d;
    logic       u;

    initial begin
        n_checks = 0; n_errors = 0;
        exp_used = 0; exp_d = 0; exp_ferr = 0; exp_ovf = 0;
        n_ferr_seen = 0; n_ovf_seen = 0;
        chk_ready = 1'b1;
        rst = 1'b0; rx = 1'b1; baud = 16'd2; rd = 1'b0;
        idle(4);
        rst = 1'b1;
        idle(4);
        check("reset_ready", {31'd0, ready}, 0);
        check("reset_D", {24'd0, dout}, 0);

        // 1: single byte at baud 2
        send_frame(8'h55, 1'b1, 2, 0);
        check("t1_ready", {31'd0, ready}, 1);
        read_byte(d, u);
        check("t1_used", {31'd0, u}, 1);
        check("t1_data", {24'd0, d}, 32'h55);
        check("t1_ready_after", {31'd0, ready}, 0);

        // 2: back-to-back frames at baud 1, then read in order
        send_frame(8'h00, 1'b1, 1, 0);
        send_frame(8'hFF, 1'b1, 1, 0);
        send_frame(8'hA5, 1'b1, 1, 0);
        read_byte(d, u); check("t2_b0", {23'd0, u, d}, 32'h100);
        read_byte(d, u); check("t2_b1", {23'd0, u, d}, 32'h1FF);
        read_byte(d, u); check("t2_b2", {23'd0, u, d}, 32'h1A5);
        read_byte(d, u); check("t2_empty_read", {31'd0, u}, 0);

        // 3: framing error with the line held low well past the frame
        send_frame(8'h3C, 1'b0, 1, 60);
        idle(4);
        check("t3_ferr_count", n_ferr_seen, 1);
        check("t3_ready", {31'd0, ready}, 0);
        idle(20);
        send_frame(8'h11, 1'b1, 1, 0);
        read_byte(d, u); check("t3_rx", {23'd0, u, d}, 32'h111);
        check("t3_ferr_model", n_ferr_seen, exp_ferr);

        // 4: overflow on the 17th byte
        for (int i = 0; i < 17; i++)
            send_frame(8'(i), 1'b1, 1, 0);
        idle(4);
        check("t4_ovf_count", n_ovf_seen, 1);
        check("t4_ovf_model", n_ovf_seen, exp_ovf);
        for (int i = 0; i < 16; i++) begin
            read_byte(d, u);
            check("t4_drain", {23'd0, u, d}, 32'h100 | i);
        end
        read_byte(d, u); check("t4_empty", {31'd0, u}, 0);

        // 5: 10-clock glitch at baud 4
        baud = 16'd4;
        idle(4);
        rx = 1'b0;
        idle(10);
        rx = 1'b1;
        idle(80);
        check("t5_ready", {31'd0, ready}, 0);
        check("t5_ferr", n_ferr_seen, exp_ferr);
        check("t5_ovf", n_ovf_seen, exp_ovf);
        send_frame(8'hC3, 1'b1, 4, 0);
        read_byte(d, u); check("t5_after", {23'd0, u, d}, 32'h1C3);

        // 6: reset in the middle of a frame with two bytes queued
        send_frame(8'h21, 1'b1, 1, 0);
        send_frame(8'h22, 1'b1, 1, 0);
        check("t6_ready_before", {31'd0, ready}, 1);
        chk_ready = 1'b0;
        @(posedge clk); #1 rx = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 rx = 1'(8'h77 >> i);
            repeat (16) @(posedge clk);
        end
        #3 rst = 1'b0;
        q.delete();
        exp_used = 1'b0; exp_d = 8'h00;
        #1;
        check("t6_rst_ready", {31'd0, ready}, 0);
        check("t6_rst_used", {31'd0, used}, 0);
        check("t6_rst_D", {24'd0, dout}, 0);
        check("t6_rst_ferr", {31'd0, ferr}, 0);
        check("t6_rst_ovf", {31'd0, ovf}, 0);
        idle(3);
        rx = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(4);
        chk_ready = 1'b1;
        idle(4);
        send_frame(8'h42, 1'b1, 1, 0);
        read_byte(d, u); check("t6_only", {23'd0, u, d}, 32'h142);
        read_byte(d, u); check("t6_empty", {31'd0, u}, 0);
        check("t6_ferr", n_ferr_seen, exp_ferr);
        check("t6_ovf", n_ovf_seen, exp_ovf);

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
